// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory.
// LS normally wins; a starvation counter guarantees IF progress.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module mem_port_arbiter #(
    parameter int MEM_AW     = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  if_req_i,
    input  logic [`CPU_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [`CPU_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [`CPU_WIDTH-1:0] ls_addr_i,
    input  logic [`CPU_WIDTH-1:0] ls_wdata_i,
    input  logic [3:0]            ls_be_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [`CPU_WIDTH-1:0] ls_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [`CPU_WIDTH-1:0] mem_wdata_o,
    input  logic [`CPU_WIDTH-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 2);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2
    } resp_t;

    resp_t         r_resp_q;
    resp_t         w_resp_d;
    logic          r_ls_we_q;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_d;
    logic          w_starved;
    logic          w_if_gnt;
    logic          w_ls_gnt;

    // Byte-offset and wrap bits are dropped on purpose.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_addr_i[`CPU_WIDTH-1:MEM_AW+2],
                             if_addr_i[1:0],
                             ls_addr_i[`CPU_WIDTH-1:MEM_AW+2],
                             ls_addr_i[1:0]};

    assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));

    // Grant: LS first unless IF has waited STARVE_MAX LS grants; none in reset.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (rst_n_i) begin
            if (ls_req_i && !(if_req_i && w_starved)) begin
                w_ls_gnt = 1'b1;
            end else if (if_req_i) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign if_gnt_o = w_if_gnt;
    assign ls_gnt_o = w_ls_gnt;

    // Steer the winner's request onto the memory port.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_ls_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_be_i;
            mem_addr_o  = ls_addr_i[MEM_AW+1:2];
            mem_wdata_o = ls_wdata_i;
        end else if (w_if_gnt) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i[MEM_AW+1:2];
        end
    end

    // Next response owner and starvation count.
    always_comb begin
        w_resp_d   = RESP_NONE;
        w_starve_d = r_starve_cnt;
        if (w_ls_gnt) begin
            w_resp_d = RESP_LS;
        end else if (w_if_gnt) begin
            w_resp_d = RESP_IF;
        end
        if (w_ls_gnt && if_req_i) begin
            if (!w_starved) begin
                w_starve_d = r_starve_cnt + 1'b1;
            end
        end else if (w_if_gnt || !if_req_i) begin
            w_starve_d = '0;
        end
    end

    // State registers; reset drops any owed response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_resp_q     <= RESP_NONE;
            r_ls_we_q    <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_resp_q     <= w_resp_d;
            r_ls_we_q    <= w_ls_gnt & ls_we_i;
            r_starve_cnt <= w_starve_d;
        end
    end

    assign if_rvalid_o = (r_resp_q == RESP_IF);
    assign ls_rvalid_o = (r_resp_q == RESP_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = (ls_rvalid_o && !r_ls_we_q) ? mem_rdata_i : '0;

endmodule
